// File: rtl/ddr_lane_serdes.sv
// DDR block framer for DATA_WIDTH eMMC lanes: start bit, payload, per-lane per-edge CRC16, end bit.
// Separate TX and RX FSMs share the lines half-duplex; only one may be active at a time.
//   state    | meaning
//   TX_IDLE  | lines high, OE low, waiting for tx_start
//   TX_START | start bit (lines low), first word accepted
//   TX_DATA  | payload beats; next word accepted except on final beat
//   TX_CRC   | 16 beats of CRC, MSB first
//   TX_END   | end bit (lines high), tx_done
//   RX_IDLE  | receiver disarmed
//   RX_WAIT  | armed, watching pos lanes for the start bit, timeout running
//   RX_DATA  | sampling payload beats
//   RX_CRC   | comparing 16 received CRC beats against the running CRC
//   RX_END   | sampling end bit, status reported next cycle
module ddr_lane_serdes #(
    parameter int DATA_WIDTH  = 8,
    parameter int BLOCK_BYTES = 512,
    parameter int RX_TIMEOUT  = 1024
) (
    input  logic                      i_clk,
    input  logic                      i_rst_n,
    input  logic                      i_tx_start,
    input  logic [2*DATA_WIDTH-1:0]   i_tx_data,
    input  logic                      i_tx_valid,
    output logic                      o_tx_ready,
    output logic                      o_tx_busy,
    output logic                      o_tx_done,
    output logic                      o_tx_underrun,
    input  logic                      i_rx_start,
    output logic [2*DATA_WIDTH-1:0]   o_rx_data,
    output logic                      o_rx_valid,
    output logic                      o_rx_busy,
    output logic                      o_rx_done,
    output logic                      o_rx_crc_err,
    output logic                      o_rx_end_err,
    output logic                      o_rx_timeout,
    output logic [DATA_WIDTH-1:0]     o_write_data_pos,
    output logic [DATA_WIDTH-1:0]     o_write_data_neg,
    output logic                      o_ddr_oe,
    input  logic [DATA_WIDTH-1:0]     i_read_data_pos,
    input  logic [DATA_WIDTH-1:0]     i_read_data_neg
);
    localparam int W2    = 2 * DATA_WIDTH;
    localparam int BEATS = BLOCK_BYTES * 8 / W2;
    localparam int MAX_A = (BEATS > 16) ? BEATS : 16;
    localparam int MAX_C = (MAX_A > RX_TIMEOUT) ? MAX_A : RX_TIMEOUT;
    localparam int CW    = $clog2(MAX_C);
    localparam logic [CW-1:0] BEATS_M1 = CW'(BEATS - 1);
    localparam logic [CW-1:0] CRC_M1   = CW'(15);
    localparam logic [CW-1:0] TO_M1    = CW'(RX_TIMEOUT - 1);

    typedef enum logic [2:0] {TX_IDLE, TX_START, TX_DATA, TX_CRC, TX_END} tx_state_t;
    typedef enum logic [2:0] {RX_IDLE, RX_WAIT, RX_DATA, RX_CRC, RX_END} rx_state_t;

    tx_state_t               r_tx_state;
    rx_state_t               r_rx_state;
    logic [CW-1:0]           r_tx_cnt;
    logic [CW-1:0]           r_rx_cnt;
    logic [15:0]             r_tx_crc [W2];
    logic [15:0]             r_rx_crc [W2];
    logic [DATA_WIDTH-1:0]   r_wr_pos;
    logic [DATA_WIDTH-1:0]   r_wr_neg;
    logic                    r_ddr_oe;
    logic                    r_tx_busy;
    logic                    r_tx_done;
    logic                    r_tx_underrun;
    logic [W2-1:0]           r_rx_data;
    logic                    r_rx_valid;
    logic                    r_rx_busy;
    logic                    r_rx_done;
    logic                    r_rx_crc_err;
    logic                    r_rx_end_err;
    logic                    r_rx_timeout;
    logic                    r_rx_err_acc;

    logic [W2-1:0]           w_tx_crc_msb;
    logic [W2-1:0]           w_rx_crc_msb;
    logic [W2-1:0]           w_rx_word;
    logic                    w_both_idle;
    logic                    w_tx_go;
    logic                    w_rx_go;
    logic                    w_tx_ready;

    // Serial CRC16-CCITT step, poly 0x1021, MSB first.
    function automatic logic [15:0] crc_step(input logic [15:0] crc, input logic bit_in);
        return {crc[14:0], 1'b0} ^ ((bit_in ^ crc[15]) ? 16'h1021 : 16'h0000);
    endfunction

    // CRC index j tracks word bit j: the upper DW indices are pos-edge lanes, the lower DW neg-edge.
    always_comb begin
        w_tx_crc_msb = '0;
        w_rx_crc_msb = '0;
        for (int j = 0; j < W2; j++) begin
            w_tx_crc_msb[j] = r_tx_crc[j][15];
            w_rx_crc_msb[j] = r_rx_crc[j][15];
        end
    end

    assign w_rx_word   = {i_read_data_pos, i_read_data_neg};
    assign w_both_idle = (r_tx_state == TX_IDLE) && (r_rx_state == RX_IDLE);
    assign w_tx_go     = i_tx_start && w_both_idle;
    assign w_rx_go     = i_rx_start && !i_tx_start && w_both_idle;
    assign w_tx_ready  = (r_tx_state == TX_START) || ((r_tx_state == TX_DATA) && (r_tx_cnt != '0));

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_tx_state    <= TX_IDLE;
            r_tx_cnt      <= '0;
            r_wr_pos      <= '1;
            r_wr_neg      <= '1;
            r_ddr_oe      <= 1'b0;
            r_tx_busy     <= 1'b0;
            r_tx_done     <= 1'b0;
            r_tx_underrun <= 1'b0;
            for (int j = 0; j < W2; j++) r_tx_crc[j] <= '0;
        end else begin
            r_tx_done     <= 1'b0;
            r_tx_underrun <= 1'b0;
            case (r_tx_state)
                TX_IDLE: begin
                    if (w_tx_go) begin
                        r_tx_state <= TX_START;
                        r_wr_pos   <= '0;
                        r_wr_neg   <= '0;
                        r_ddr_oe   <= 1'b1;
                        r_tx_busy  <= 1'b1;
                        for (int j = 0; j < W2; j++) r_tx_crc[j] <= '0;
                    end
                end
                TX_START, TX_DATA: begin
                    if (w_tx_ready) begin
                        if (i_tx_valid) begin
                            {r_wr_pos, r_wr_neg} <= i_tx_data;
                            for (int j = 0; j < W2; j++) r_tx_crc[j] <= crc_step(r_tx_crc[j], i_tx_data[j]);
                            r_tx_cnt   <= (r_tx_state == TX_START) ? BEATS_M1 : r_tx_cnt - 1'b1;
                            r_tx_state <= TX_DATA;
                        end else begin
                            r_tx_underrun <= 1'b1;
                            r_wr_pos      <= '1;
                            r_wr_neg      <= '1;
                            r_ddr_oe      <= 1'b0;
                            r_tx_busy     <= 1'b0;
                            r_tx_state    <= TX_IDLE;
                        end
                    end else begin
                        // Final payload beat: the CRC already covers every accepted word.
                        {r_wr_pos, r_wr_neg} <= w_tx_crc_msb;
                        for (int j = 0; j < W2; j++) r_tx_crc[j] <= {r_tx_crc[j][14:0], 1'b0};
                        r_tx_cnt   <= CRC_M1;
                        r_tx_state <= TX_CRC;
                    end
                end
                TX_CRC: begin
                    if (r_tx_cnt != '0) begin
                        {r_wr_pos, r_wr_neg} <= w_tx_crc_msb;
                        for (int j = 0; j < W2; j++) r_tx_crc[j] <= {r_tx_crc[j][14:0], 1'b0};
                        r_tx_cnt <= r_tx_cnt - 1'b1;
                    end else begin
                        r_wr_pos   <= '1;
                        r_wr_neg   <= '1;
                        r_tx_done  <= 1'b1;
                        r_tx_state <= TX_END;
                    end
                end
                TX_END: begin
                    r_ddr_oe   <= 1'b0;
                    r_tx_busy  <= 1'b0;
                    r_tx_state <= TX_IDLE;
                end
                default: r_tx_state <= TX_IDLE;
            endcase
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_rx_state   <= RX_IDLE;
            r_rx_cnt     <= '0;
            r_rx_data    <= '0;
            r_rx_valid   <= 1'b0;
            r_rx_busy    <= 1'b0;
            r_rx_done    <= 1'b0;
            r_rx_crc_err <= 1'b0;
            r_rx_end_err <= 1'b0;
            r_rx_timeout <= 1'b0;
            r_rx_err_acc <= 1'b0;
            for (int j = 0; j < W2; j++) r_rx_crc[j] <= '0;
        end else begin
            r_rx_valid   <= 1'b0;
            r_rx_done    <= 1'b0;
            r_rx_crc_err <= 1'b0;
            r_rx_end_err <= 1'b0;
            r_rx_timeout <= 1'b0;
            case (r_rx_state)
                RX_IDLE: begin
                    if (w_rx_go) begin
                        r_rx_state <= RX_WAIT;
                        r_rx_cnt   <= TO_M1;
                        r_rx_busy  <= 1'b1;
                    end
                end
                RX_WAIT: begin
                    if (i_read_data_pos == '0) begin
                        r_rx_state   <= RX_DATA;
                        r_rx_cnt     <= BEATS_M1;
                        r_rx_err_acc <= 1'b0;
                        for (int j = 0; j < W2; j++) r_rx_crc[j] <= '0;
                    end else if (r_rx_cnt == '0) begin
                        r_rx_timeout <= 1'b1;
                        r_rx_busy    <= 1'b0;
                        r_rx_state   <= RX_IDLE;
                    end else begin
                        r_rx_cnt <= r_rx_cnt - 1'b1;
                    end
                end
                RX_DATA: begin
                    r_rx_data  <= w_rx_word;
                    r_rx_valid <= 1'b1;
                    for (int j = 0; j < W2; j++) r_rx_crc[j] <= crc_step(r_rx_crc[j], w_rx_word[j]);
                    if (r_rx_cnt == '0) begin
                        r_rx_cnt   <= CRC_M1;
                        r_rx_state <= RX_CRC;
                    end else begin
                        r_rx_cnt <= r_rx_cnt - 1'b1;
                    end
                end
                RX_CRC: begin
                    if (|(w_rx_word ^ w_rx_crc_msb)) r_rx_err_acc <= 1'b1;
                    for (int j = 0; j < W2; j++) r_rx_crc[j] <= {r_rx_crc[j][14:0], 1'b0};
                    if (r_rx_cnt == '0) r_rx_state <= RX_END;
                    else                r_rx_cnt   <= r_rx_cnt - 1'b1;
                end
                RX_END: begin
                    r_rx_done    <= 1'b1;
                    r_rx_crc_err <= r_rx_err_acc;
                    r_rx_end_err <= (i_read_data_pos != '1);
                    r_rx_busy    <= 1'b0;
                    r_rx_state   <= RX_IDLE;
                end
                default: r_rx_state <= RX_IDLE;
            endcase
        end
    end

    assign o_tx_ready       = w_tx_ready;
    assign o_tx_busy        = r_tx_busy;
    assign o_tx_done        = r_tx_done;
    assign o_tx_underrun    = r_tx_underrun;
    assign o_rx_data        = r_rx_data;
    assign o_rx_valid       = r_rx_valid;
    assign o_rx_busy        = r_rx_busy;
    assign o_rx_done        = r_rx_done;
    assign o_rx_crc_err     = r_rx_crc_err;
    assign o_rx_end_err     = r_rx_end_err;
    assign o_rx_timeout     = r_rx_timeout;
    assign o_write_data_pos = r_wr_pos;
    assign o_write_data_neg = r_wr_neg;
    assign o_ddr_oe         = r_ddr_oe;
endmodule

// File: tb/tb_ddr_lane_serdes.sv
// Bench for ddr_lane_serdes: instance a transmits into instance b (with optional bit flips),
// instance c (single lane, full 512-byte block) is used for the mid-block reset case.
module tb_ddr_lane_serdes;
    localparam int DW    = 8;
    localparam int BB    = 4;
    localparam int BEATS = BB * 8 / (2 * DW);
    localparam int TO    = 16;

    typedef logic [15:0] blk_t [BEATS];

    logic clk = 1'b0;
    always #5 clk = ~clk;
    logic rst_n;
    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int checks = 0;
    int errors = 0;

    // instance a: transmitter
    logic a_tx_start, a_tx_valid, a_tx_ready, a_tx_busy, a_tx_done, a_tx_underrun;
    logic [15:0] a_tx_data, a_rx_data;
    logic a_rx_start, a_rx_valid, a_rx_busy, a_rx_done, a_rx_crc_err, a_rx_end_err, a_rx_timeout;
    logic [7:0] a_wr_pos, a_wr_neg, a_rd_pos, a_rd_neg;
    logic a_oe;
    // instance b: receiver looped back from a
    logic b_tx_start, b_tx_valid, b_tx_ready, b_tx_busy, b_tx_done, b_tx_underrun;
    logic [15:0] b_tx_data, b_rx_data;
    logic b_rx_start, b_rx_valid, b_rx_busy, b_rx_done, b_rx_crc_err, b_rx_end_err, b_rx_timeout;
    logic [7:0] b_wr_pos, b_wr_neg, b_rd_pos, b_rd_neg;
    logic b_oe;
    logic [7:0] flip_pos, flip_neg;
    // instance c: DW=1
    logic c_tx_start, c_tx_valid, c_tx_ready, c_tx_busy, c_tx_done, c_tx_underrun;
    logic [1:0] c_tx_data, c_rx_data;
    logic c_rx_start, c_rx_valid, c_rx_busy, c_rx_done, c_rx_crc_err, c_rx_end_err, c_rx_timeout;
    logic c_wr_pos, c_wr_neg, c_rd_pos, c_rd_neg, c_oe;

    assign b_rd_pos = a_wr_pos ^ flip_pos;
    assign b_rd_neg = a_wr_neg ^ flip_neg;

    ddr_lane_serdes #(.DATA_WIDTH(DW), .BLOCK_BYTES(BB), .RX_TIMEOUT(TO)) u_a (
        .i_clk(clk), .i_rst_n(rst_n), .i_tx_start(a_tx_start), .i_tx_data(a_tx_data),
        .i_tx_valid(a_tx_valid), .o_tx_ready(a_tx_ready), .o_tx_busy(a_tx_busy),
        .o_tx_done(a_tx_done), .o_tx_underrun(a_tx_underrun), .i_rx_start(a_rx_start),
        .o_rx_data(a_rx_data), .o_rx_valid(a_rx_valid), .o_rx_busy(a_rx_busy),
        .o_rx_done(a_rx_done), .o_rx_crc_err(a_rx_crc_err), .o_rx_end_err(a_rx_end_err),
        .o_rx_timeout(a_rx_timeout), .o_write_data_pos(a_wr_pos), .o_write_data_neg(a_wr_neg),
        .o_ddr_oe(a_oe), .i_read_data_pos(a_rd_pos), .i_read_data_neg(a_rd_neg));

    ddr_lane_serdes #(.DATA_WIDTH(DW), .BLOCK_BYTES(BB), .RX_TIMEOUT(TO)) u_b (
        .i_clk(clk), .i_rst_n(rst_n), .i_tx_start(b_tx_start), .i_tx_data(b_tx_data),
        .i_tx_valid(b_tx_valid), .o_tx_ready(b_tx_ready), .o_tx_busy(b_tx_busy),
        .o_tx_done(b_tx_done), .o_tx_underrun(b_tx_underrun), .i_rx_start(b_rx_start),
        .o_rx_data(b_rx_data), .o_rx_valid(b_rx_valid), .o_rx_busy(b_rx_busy),
        .o_rx_done(b_rx_done), .o_rx_crc_err(b_rx_crc_err), .o_rx_end_err(b_rx_end_err),
        .o_rx_timeout(b_rx_timeout), .o_write_data_pos(b_wr_pos), .o_write_data_neg(b_wr_neg),
        .o_ddr_oe(b_oe), .i_read_data_pos(b_rd_pos), .i_read_data_neg(b_rd_neg));

    ddr_lane_serdes #(.DATA_WIDTH(1), .BLOCK_BYTES(512), .RX_TIMEOUT(1024)) u_c (
        .i_clk(clk), .i_rst_n(rst_n), .i_tx_start(c_tx_start), .i_tx_data(c_tx_data),
        .i_tx_valid(c_tx_valid), .o_tx_ready(c_tx_ready), .o_tx_busy(c_tx_busy),
        .o_tx_done(c_tx_done), .o_tx_underrun(c_tx_underrun), .i_rx_start(c_rx_start),
        .o_rx_data(c_rx_data), .o_rx_valid(c_rx_valid), .o_rx_busy(c_rx_busy),
        .o_rx_done(c_rx_done), .o_rx_crc_err(c_rx_crc_err), .o_rx_end_err(c_rx_end_err),
        .o_rx_timeout(c_rx_timeout), .o_write_data_pos(c_wr_pos), .o_write_data_neg(c_wr_neg),
        .o_ddr_oe(c_oe), .i_read_data_pos(c_rd_pos), .i_read_data_neg(c_rd_neg));

    // scoreboard queues
    logic [15:0] q_lines[$];
    logic [15:0] q_rx_data[$];
    logic [1:0]  q_rx_stat[$];
    int          q_done_cyc[$];
    int          q_under_cyc[$];
    int          q_to_cyc[$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cyc %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic unexpected(input string name);
        checks++;
        errors++;
        $display("FAIL %s: DUT event with no expected entry (cyc %0d)", name, cyc);
    endtask

    // Reference CRC for one lane/edge: serial over the payload bits of that lane, oldest beat first.
    function automatic logic [15:0] ref_crc(input blk_t w, input int lane);
        logic [15:0] c;
        logic fb;
        c = 16'h0000;
        for (int b = 0; b < BEATS; b++) begin
            fb = w[b][lane] ^ c[15];
            c  = (c << 1) ^ (fb ? 16'h1021 : 16'h0000);
        end
        return c;
    endfunction

    task automatic push_tx_trace(input blk_t w);
        logic [15:0] crc [16];
        logic [15:0] ln;
        for (int j = 0; j < 16; j++) crc[j] = ref_crc(w, j);
        q_lines.push_back(16'h0000);
        for (int b = 0; b < BEATS; b++) q_lines.push_back(w[b]);
        for (int k = 0; k < 16; k++) begin
            for (int j = 0; j < 16; j++) ln[j] = crc[j][15-k];
            q_lines.push_back(ln);
        end
        q_lines.push_back(16'hFFFF);
    endtask

    always @(negedge clk) begin
        if (rst_n) begin
            if (a_oe) begin
                if (q_lines.size() == 0) unexpected("tx_lines");
                else chk("tx_lines", {a_wr_pos, a_wr_neg}, q_lines.pop_front());
            end else begin
                chk("tx_idle_lines", {a_wr_pos, a_wr_neg}, 16'hFFFF);
            end
            if (a_tx_done) begin
                if (q_done_cyc.size() == 0) unexpected("tx_done");
                else chk("tx_done_cycle", cyc, q_done_cyc.pop_front());
            end
            if (a_tx_underrun) begin
                if (q_under_cyc.size() == 0) unexpected("tx_underrun");
                else chk("tx_underrun_cycle", cyc, q_under_cyc.pop_front());
            end
            if (b_rx_valid) begin
                if (q_rx_data.size() == 0) unexpected("rx_data");
                else chk("rx_data", b_rx_data, q_rx_data.pop_front());
            end
            if (b_rx_done) begin
                if (q_rx_stat.size() == 0) unexpected("rx_done");
                else chk("rx_status{crc,end}", {b_rx_crc_err, b_rx_end_err}, q_rx_stat.pop_front());
            end
            if (b_rx_timeout) begin
                if (q_to_cyc.size() == 0) unexpected("rx_timeout");
                else chk("rx_timeout_cycle", cyc, q_to_cyc.pop_front());
            end
        end
    end

    // modes: 0 clean, 1 neg lane3 flip in a CRC beat, 2 pos flip on end bit, 3 payload flip, 4 underrun
    task automatic run_block(input int mode, input blk_t w, input bit arb);
        int c0;
        int idx;
        int k;
        logic [7:0]  m;
        logic [15:0] dmask;
        k     = $urandom_range(0, 15);
        m     = 8'(1 << $urandom_range(0, 7));
        dmask = 16'(1 << $urandom_range(0, 15));
        if (mode != 4) begin
            @(negedge clk);
            b_rx_start = 1'b1;
            @(negedge clk);
            b_rx_start = 1'b0;
            for (int b = 0; b < BEATS; b++)
                q_rx_data.push_back(w[b] ^ ((mode == 3 && b == BEATS - 1) ? dmask : 16'h0000));
            q_rx_stat.push_back({(mode == 1 || mode == 3), (mode == 2)});
            push_tx_trace(w);
        end else begin
            q_lines.push_back(16'h0000);
            q_lines.push_back(w[0]);
        end
        @(negedge clk);
        c0 = cyc;
        a_tx_start = 1'b1;
        a_rx_start = arb;
        a_tx_valid = 1'b1;
        a_tx_data  = w[0];
        idx = 0;
        if (mode != 4) q_done_cyc.push_back(c0 + BEATS + 18);
        else           q_under_cyc.push_back(c0 + 3);
        for (int c = 1; c <= BEATS + 22; c++) begin
            @(negedge clk);
            a_tx_start = 1'b0;
            a_rx_start = (arb && c == 5);
            flip_pos = 8'h00;
            flip_neg = 8'h00;
            if (idx < BEATS) a_tx_data = w[idx];
            a_tx_valid = !(mode == 4 && idx == 1);
            if (a_tx_ready && a_tx_valid) idx++;
            if (mode == 1 && c == BEATS + 2 + k) flip_neg = 8'h08;
            if (mode == 2 && c == BEATS + 18)    flip_pos = m;
            if (mode == 3 && c == BEATS + 1)     {flip_pos, flip_neg} = dmask;
            if (c == 1) chk("tx_busy_start", a_tx_busy, 1);
            if (c == BEATS + 19) begin
                chk("oe_after_block", a_oe, 0);
                chk("tx_busy_after_block", a_tx_busy, 0);
            end
            if (arb && (c == 1 || c == 6)) chk("arb_rx_blocked", a_rx_busy, 0);
        end
        a_tx_valid = 1'b0;
        a_rx_start = 1'b0;
    endtask

    task automatic run_timeout();
        @(negedge clk);
        b_rx_start = 1'b1;
        q_to_cyc.push_back(cyc + TO + 1);
        for (int c = 1; c <= TO + 4; c++) begin
            @(negedge clk);
            b_rx_start = 1'b0;
            if (c == TO)     chk("rx_busy_waiting", b_rx_busy, 1);
            if (c == TO + 1) chk("rx_busy_after_timeout", b_rx_busy, 0);
        end
    endtask

    task automatic run_c_reset();
        logic [1:0] prev;
        @(negedge clk);
        c_tx_start = 1'b1;
        c_tx_valid = 1'b1;
        c_tx_data  = 2'($urandom);
        prev = c_tx_data;
        for (int c = 1; c <= 1000; c++) begin
            @(negedge clk);
            c_tx_start = 1'b0;
            if (c == 1) chk("c_start_bit", {c_wr_pos, c_wr_neg}, 2'b00);
            else        chk("c_data_beat", {c_wr_pos, c_wr_neg}, prev);
            c_tx_data = 2'($urandom);
            if (c >= 1) prev = c_tx_data;
        end
        chk("c_oe_mid_data", c_oe, 1);
        chk("c_busy_mid_data", c_tx_busy, 1);
        #2 rst_n = 1'b0;
        #1;
        chk("c_reset_lines", {c_wr_pos, c_wr_neg}, 2'b11);
        chk("c_reset_oe", c_oe, 0);
        chk("c_reset_busy", c_tx_busy, 0);
        @(negedge clk);
        rst_n = 1'b1;
        c_tx_valid = 1'b0;
        for (int c = 0; c < 40; c++) begin
            @(negedge clk);
            chk("c_no_done_after_reset", {c_tx_done, c_tx_underrun, c_oe}, 3'b000);
        end
    endtask

    initial begin
        blk_t w;
        int mode;
        rst_n = 1'b0;
        a_tx_start = 0; a_tx_valid = 0; a_tx_data = '0; a_rx_start = 0; a_rd_pos = '1; a_rd_neg = '1;
        b_tx_start = 0; b_tx_valid = 0; b_tx_data = '0; b_rx_start = 0;
        c_tx_start = 0; c_tx_valid = 0; c_tx_data = '0; c_rx_start = 0; c_rd_pos = 1; c_rd_neg = 1;
        flip_pos = '0; flip_neg = '0;
        #12;
        chk("reset_lines", {a_wr_pos, a_wr_neg}, 16'hFFFF);
        chk("reset_oe", a_oe, 0);
        chk("reset_rx_data", b_rx_data, 16'h0000);
        chk("reset_flags", {a_tx_busy, a_tx_done, a_tx_underrun, a_tx_ready,
                            b_rx_busy, b_rx_valid, b_rx_done, b_rx_timeout}, 8'h00);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

        w = '{16'hFF00, 16'h0000};
        run_block(0, w, 1'b0);
        run_block(1, w, 1'b0);
        for (int i = 0; i < 8; i++) begin
            for (int b = 0; b < BEATS; b++) w[b] = 16'($urandom);
            mode = (i < 4) ? i : $urandom_range(0, 3);
            run_block(mode, w, (i == 2));
        end
        for (int b = 0; b < BEATS; b++) w[b] = 16'($urandom);
        run_block(4, w, 1'b0);
        run_timeout();
        run_c_reset();

        repeat (3) @(negedge clk);
        chk("left_tx_lines", q_lines.size(), 0);
        chk("left_rx_data", q_rx_data.size(), 0);
        chk("left_rx_stat", q_rx_stat.size(), 0);
        chk("left_done", q_done_cyc.size(), 0);
        chk("left_underrun", q_under_cyc.size(), 0);
        chk("left_timeout", q_to_cyc.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/ddr_lane_serdes.md
Name: ddr_lane_serdes

Overview:
- Parametrised successor to the single-line eMMC DDR I/O unit.
- Drives and samples DATA_WIDTH eMMC data lines as per-edge (pos/neg) bit pairs, and frames a complete DDR data block: start bit, payload, per-line per-edge CRC16, end bit.
- Sits between the host data FIFO and the per-line DDR I/O cells.
- Adds framing, CRC generation/check, underrun abort and receive timeout, none of which the single-line unit has.

Parameters:
- DATA_WIDTH, 8, number of eMMC data lines (1, 4 or 8).
- BLOCK_BYTES, 512, payload bytes per block; BLOCK_BYTES*8 must be divisible by 2*DATA_WIDTH.
- RX_TIMEOUT, 1024, cycles to wait for a start bit before timeout.

Ports:
- Clk  in  1  block clock; one DDR beat per cycle.
- Reset  in  1  asynchronous, active-low reset.
- tx_start  in  1  pulse: begin transmitting one block.
- tx_data  in  2*DATA_WIDTH  payload beat; [2*DW-1:DW] on pos edge, [DW-1:0] on neg edge.
- tx_valid  in  1  tx_data valid.
- tx_ready  out  1  block consumes tx_data this cycle if tx_valid.
- tx_busy  out  1  transmit in progress.
- tx_done  out  1  pulse: block finished (end bit cycle).
- tx_underrun  out  1  pulse: tx_ready high while tx_valid low; block aborted.
- rx_start  in  1  pulse: arm receiver.
- rx_data  out  2*DATA_WIDTH  received payload beat, same packing as tx_data.
- rx_valid  out  1  rx_data valid; no backpressure.
- rx_busy  out  1  receiver armed or receiving.
- rx_done  out  1  pulse: block received; status valid this cycle.
- rx_crc_err  out  1  valid with rx_done: any lane/edge CRC mismatch.
- rx_end_err  out  1  valid with rx_done: end bit not all-ones.
- rx_timeout  out  1  pulse: no start bit within RX_TIMEOUT cycles.
- WriteData_posEdge  out  DATA_WIDTH  to DDR output cells, pos-edge bits.
- WriteData_negEdge  out  DATA_WIDTH  to DDR output cells, neg-edge bits.
- DDR_OE  out  1  line output enable.
- ReadData_posEdge  in  DATA_WIDTH  from DDR input cells.
- ReadData_negEdge  in  DATA_WIDTH  from DDR input cells.

Behaviour:
- Derived constants:
  - BEATS = BLOCK_BYTES*8/(2*DATA_WIDTH).
  - Beat counter width = clog2(max(BEATS, 16, RX_TIMEOUT)).
- Reset (async assert, sync deassert by design context):
  - WriteData_* all 1, DDR_OE=0, rx_data=0.
  - All pulses, flags and busy signals 0.
  - Both FSMs in IDLE.
- All outputs are registered except tx_ready, which decodes from state.
- TX FSM: IDLE -> START -> DATA -> CRC -> END -> IDLE, plus ABORT path.
  - IDLE: lines 1, OE=0. tx_start -> START next cycle (cycle T+1).
  - START, 1 cycle: lines 0, OE=1, tx_ready=1. The accepted word appears on the lines in the first DATA cycle.
  - DATA, BEATS cycles: lines = accepted word. tx_ready=1 except in the final beat.
  - CRC, 16 cycles: beat k drives bit 15-k of each of the 2*DW CRCs; pos CRC on pos lines, neg CRC on neg lines.
  - END, 1 cycle: lines 1, tx_done=1, OE=1. Then IDLE with OE=0.
  - Underrun: tx_ready=1 && tx_valid=0 -> tx_underrun pulse, lines 1, OE=0, back to IDLE next cycle. No CRC, no tx_done.
- CRC:
  - One CRC16 per lane per edge, poly 0x1021, init 0x0000, MSB-first serial over that lane/edge's payload bits.
  - Update per bit: fb = bit ^ crc[15]; crc = (crc<<1) ^ (fb ? 0x1021 : 0).
  - CRCs are cleared on entry to START (TX) and on start detect (RX).
- RX FSM: IDLE -> WAIT -> DATA -> CRC -> END -> IDLE.
  - rx_start -> WAIT; timeout counter cleared.
  - WAIT: start detect when ReadData_posEdge all 0. After RX_TIMEOUT cycles with no start: rx_timeout pulse, go to IDLE.
  - DATA: BEATS beats; each beat presented on rx_data with rx_valid=1 one cycle after sampling.
  - CRC: 16 beats; received bits compared with the computed CRC, mismatches sticky.
  - END: sample pos lanes. rx_done one cycle later with rx_crc_err and rx_end_err (pos lanes != all 1).
- Arbitration:
  - tx_start and rx_start together in IDLE: TX wins, rx_start dropped.
  - Either start while either FSM is busy is ignored.
- Reset mid-block: immediate return to IDLE/reset values; no done or error pulse.

Test Plan:
- DW=8, BLOCK_BYTES=4 (BEATS=2); TX beats 0xFF00, 0x0000 ->
  - START lines 0; DATA pos=0xFF,neg=0x00 then 0x00/0x00.
  - CRC beats k=2,9,14: pos=0xFF, all others pos=0x00; neg=0x00 for all 16 beats.
  - END 0xFF/0xFF, tx_done at cycle T+20, OE low at T+21.
- Same config, tx_valid dropped on second beat -> tx_underrun pulse, OE=0 next cycle, no tx_done.
- Loopback (Write->Read) of the first TX, receiver armed first -> rx_data 0xFF00, 0x0000, rx_done with crc_err=0, end_err=0.
- Loopback with one neg bit of lane 3 flipped in a CRC beat -> rx_done, rx_crc_err=1.
- rx_start with lines held 1, RX_TIMEOUT=16 -> rx_timeout pulse 16 cycles after WAIT entry, rx_busy falls.
- DW=1, BLOCK_BYTES=512 -> 2048 data beats; Reset asserted mid-DATA -> lines 1, OE=0 immediately, no tx_done.
